// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: walks FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// issues every datapath timing strobe, counts retired instructions, traps on illegal ops.
module multicycle_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             alu_equal,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] instret_reg;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             opcode_legal;
  logic             is_store;
  logic             is_load;
  logic             unused_bits;

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign is_store    = (opcode == OPC_STORE);
  assign is_load     = (opcode == OPC_LOAD);
  assign unused_bits = ^{instruction[31:15], instruction[11:7]};

  always_comb begin
    case (opcode)
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM,
      OPC_LUI, OPC_BRANCH, OPC_JAL: opcode_legal = 1'b1;
      default:                      opcode_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Strobes are purely combinational and forced low while reset is held,
  // so an aborted transaction never leaks a request or write.
  always_comb begin
    state_next   = state_reg;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          state_next = opcode_legal ? S_EXECUTE : S_TRAP;
        end
        S_EXECUTE: begin
          case (opcode)
            OPC_BRANCH: begin
              if (funct3 == 3'b000 || funct3 == 3'b001) begin
                pc_write   = 1'b1;
                pc_src     = (funct3 == 3'b000) ? alu_equal : ~alu_equal;
                state_next = S_FETCH;
              end else begin
                state_next = S_TRAP;
              end
            end
            OPC_JAL: begin
              pc_write   = 1'b1;
              pc_src     = 1'b1;
              reg_write  = 1'b1;
              wb_sel     = WB_PC4;
              state_next = S_FETCH;
            end
            OPC_LOAD, OPC_STORE: state_next = S_MEMORY;
            OPC_OP, OPC_OPIMM, OPC_LUI: state_next = S_WRITEBACK;
            default: state_next = S_TRAP;
          endcase
        end
        S_MEMORY: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_store;
          if (mem_ready) begin
            if (is_store) begin
              pc_write   = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WRITEBACK;
            end
          end
        end
        S_WRITEBACK: begin
          reg_write  = 1'b1;
          wb_sel     = is_load ? WB_MEM : WB_ALU;
          pc_write   = 1'b1;
          state_next = S_FETCH;
        end
        S_TRAP: begin
          state_next = S_TRAP;
        end
        default: begin
          // Unreachable encodings are treated as a fault.
          state_next = S_TRAP;
        end
      endcase
    end
  end

  // pc_write fires exactly once per instruction, so it doubles as the retire pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_reg <= '0;
    end else if (pc_write) begin
      instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  assign state   = state_reg;
  assign trap    = (state_reg == S_TRAP);
  assign instret = instret_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: per-instruction cycle traces are derived from the ISA-level
// sequencing rules and replayed against the sequencer, one line per checked cycle on error.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic        alu_equal = 1'b0;
  logic        mem_ready = 1'b0;

  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write, trap;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  logic        w_mem_req, w_mem_we, w_mem_addr_sel, w_ir_write, w_pc_write, w_pc_src;
  logic        w_reg_write, w_trap;
  logic [1:0]  w_wb_sel;
  logic [2:0]  w_state;
  logic [3:0]  w_instret;

  int          checks = 0;
  int          errors = 0;
  int unsigned cnt = 0;

  always #5 clk = ~clk;

  multicycle_sequencer dut (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_equal(alu_equal),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .wb_sel(wb_sel), .trap(trap), .state(state), .instret(instret)
  );

  multicycle_sequencer #(.CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_equal(alu_equal),
    .mem_ready(mem_ready), .mem_req(w_mem_req), .mem_we(w_mem_we),
    .mem_addr_sel(w_mem_addr_sel), .ir_write(w_ir_write), .pc_write(w_pc_write),
    .pc_src(w_pc_src), .reg_write(w_reg_write), .wb_sel(w_wb_sel), .trap(w_trap),
    .state(w_state), .instret(w_instret)
  );

  logic [12:0] obs;
  assign obs = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                reg_write, wb_sel, trap};

  typedef struct {
    logic [31:0] ins;
    logic        eq;
    logic        rdy;
    logic [2:0]  st;
    logic        req, we, asel, irw, pcw, pcs, rw;
    logic [1:0]  wb;
    logic        tr;
  } cyc_t;

  cyc_t exp_q[$];

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  function automatic logic [12:0] pack(input cyc_t c);
    return {c.st, c.req, c.we, c.asel, c.irw, c.pcw, c.pcs, c.rw, c.wb, c.tr};
  endfunction

  // Idle cycle in a given phase; don't-care inputs are randomised.
  function automatic cyc_t blank(input logic [31:0] ins, input logic [2:0] st);
    cyc_t c;
    c = '{default: '0};
    c.ins = ins;
    c.st  = st;
    c.eq  = 1'($urandom);
    c.rdy = 1'($urandom);
    return c;
  endfunction

  task automatic push_trap(input logic [31:0] ins, input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(ins, 3'd7);
      c.tr = 1'b1;
      exp_q.push_back(c);
    end
  endtask

  task automatic push_wb(input logic [31:0] ins, input logic [1:0] sel);
    cyc_t c;
    c = blank(ins, 3'd4);
    c.rw  = 1'b1;
    c.wb  = sel;
    c.pcw = 1'b1;
    exp_q.push_back(c);
  endtask

  // Expected per-cycle trace of one instruction: wf fetch stalls, wm memory stalls.
  task automatic build(input logic [31:0] ins, input int wf, input int wm, input int ntrap);
    cyc_t c;
    logic [6:0] op;
    logic [2:0] f3;
    logic eq;
    op = ins[6:0];
    f3 = ins[14:12];
    eq = 1'($urandom);
    for (int i = 0; i < wf; i++) begin
      c = blank($urandom, 3'd0);
      c.rdy = 1'b0;
      c.req = 1'b1;
      exp_q.push_back(c);
    end
    c = blank($urandom, 3'd0);
    c.rdy = 1'b1;
    c.req = 1'b1;
    c.irw = 1'b1;
    exp_q.push_back(c);
    exp_q.push_back(blank(ins, 3'd1));
    if (!(op inside {OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_LUI, OPC_BRANCH, OPC_JAL})) begin
      push_trap(ins, ntrap);
      return;
    end
    c = blank(ins, 3'd2);
    c.eq = eq;
    if (op == OPC_BRANCH) begin
      if (f3 == 3'd0 || f3 == 3'd1) begin
        c.pcw = 1'b1;
        c.pcs = (f3 == 3'd0) ? eq : !eq;
        exp_q.push_back(c);
      end else begin
        exp_q.push_back(c);
        push_trap(ins, ntrap);
      end
    end else if (op == OPC_JAL) begin
      c.pcw = 1'b1;
      c.pcs = 1'b1;
      c.rw  = 1'b1;
      c.wb  = 2'b10;
      exp_q.push_back(c);
    end else if (op == OPC_LOAD || op == OPC_STORE) begin
      exp_q.push_back(c);
      for (int i = 0; i <= wm; i++) begin
        c = blank(ins, 3'd3);
        c.rdy  = (i == wm);
        c.req  = 1'b1;
        c.asel = 1'b1;
        c.we   = (op == OPC_STORE);
        c.pcw  = (i == wm) && (op == OPC_STORE);
        exp_q.push_back(c);
      end
      if (op == OPC_LOAD) push_wb(ins, 2'b01);
    end else begin
      exp_q.push_back(c);
      push_wb(ins, 2'b00);
    end
  endtask

  task automatic drive(input cyc_t c);
    @(negedge clk);
    instruction = c.ins;
    alu_equal   = c.eq;
    mem_ready   = c.rdy;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    instruction = $urandom;
    #1;
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", obs, 13'd0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (instret !== 32'd0 || w_instret !== 4'd0 || obs !== 13'd0) begin
      errors++;
      $display("FAIL reset_hold instret=%0d/%0d obs=%b exp 0", instret, w_instret, obs);
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    cnt = 0;
    #1;
    checks++;
    if (state !== 3'd0 || trap !== 1'b0 || mem_req !== 1'b1 || mem_addr_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_release state=%0d trap=%b req=%b asel=%b exp 0/0/1/0",
               state, trap, mem_req, mem_addr_sel);
    end
  endtask

  task automatic test_load();
    cyc_t c;
    build(32'h0014A303, 0, 0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      drive(c);
      checks++;
      if (obs !== pack(c)) begin
        errors++;
        $display("FAIL load st=%0d got=%b exp=%b", c.st, obs, pack(c));
      end
      checks++;
      if (instret !== cnt) begin
        errors++;
        $display("FAIL load_instret got=%0d exp=%0d", instret, cnt);
      end
      if (c.pcw) cnt++;
    end
  endtask

  task automatic test_alu();
    cyc_t c;
    build(32'h00A50533, 0, 0, 0);
    build(32'h00150513, 1, 0, 0);
    build(32'h123450B7, 2, 0, 0);
    build(32'h0080006F, 0, 0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      drive(c);
      checks++;
      if (obs !== pack(c)) begin
        errors++;
        $display("FAIL alu st=%0d ins=%h got=%b exp=%b", c.st, c.ins, obs, pack(c));
      end
      checks++;
      if (instret !== cnt) begin
        errors++;
        $display("FAIL alu_instret got=%0d exp=%0d", instret, cnt);
      end
      if (c.pcw) cnt++;
    end
  endtask

  task automatic test_branch();
    cyc_t c;
    for (int k = 0; k < 6; k++) begin
      build((k % 2 == 0) ? 32'h00000463 : 32'h00001463, 0, 0, 0);
      while (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        drive(c);
        checks++;
        if (obs !== pack(c)) begin
          errors++;
          $display("FAIL branch st=%0d eq=%b got=%b exp=%b", c.st, c.eq, obs, pack(c));
        end
        checks++;
        if (instret !== cnt) begin
          errors++;
          $display("FAIL branch_instret got=%0d exp=%0d", instret, cnt);
        end
        if (c.pcw) cnt++;
      end
    end
  endtask

  task automatic test_store_wait();
    cyc_t c;
    build(32'h00512023, 2, 3, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      drive(c);
      checks++;
      if (obs !== pack(c)) begin
        errors++;
        $display("FAIL store st=%0d rdy=%b got=%b exp=%b", c.st, c.rdy, obs, pack(c));
      end
      checks++;
      if (instret !== cnt) begin
        errors++;
        $display("FAIL store_instret got=%0d exp=%0d", instret, cnt);
      end
      if (c.pcw) cnt++;
    end
  endtask

  task automatic test_reset_mid();
    cyc_t c;
    build(32'h00512023, 0, 5, 0);
    for (int i = 0; i < 4; i++) begin
      c = exp_q.pop_front();
      drive(c);
      checks++;
      if (obs !== pack(c)) begin
        errors++;
        $display("FAIL mid_pre st=%0d got=%b exp=%b", c.st, obs, pack(c));
      end
    end
    exp_q.delete();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 13'd0 || instret !== 32'd0 || w_instret !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset obs=%b instret=%0d exp 0/0", obs, instret);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    cnt = 0;
    #1;
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b1 || mem_addr_sel !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_release state=%0d req=%b asel=%b we=%b exp 0/1/0/0",
               state, mem_req, mem_addr_sel, mem_we);
    end
  endtask

  task automatic test_illegal();
    cyc_t c;
    for (int k = 0; k < 2; k++) begin
      build((k == 0) ? 32'h00000000 : 32'h00002463, 0, 0, 10);
      while (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        drive(c);
        checks++;
        if (obs !== pack(c)) begin
          errors++;
          $display("FAIL illegal st=%0d got=%b exp=%b", c.st, obs, pack(c));
        end
        checks++;
        if (instret !== cnt) begin
          errors++;
          $display("FAIL illegal_instret got=%0d exp=%0d", instret, cnt);
        end
        if (c.pcw) cnt++;
      end
      test_reset();
    end
  endtask

  task automatic test_random();
    cyc_t c;
    logic [6:0] ops [7];
    logic [31:0] r;
    ops = '{OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_LUI, OPC_BRANCH, OPC_JAL};
    for (int k = 0; k < 40; k++) begin
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 6)];
      if (r[6:0] == OPC_BRANCH) r[14:12] = 3'($urandom_range(0, 1));
      build(r, $urandom_range(0, 3), $urandom_range(0, 3), 0);
      while (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        drive(c);
        checks++;
        if (obs !== pack(c)) begin
          errors++;
          $display("FAIL random st=%0d ins=%h got=%b exp=%b", c.st, c.ins, obs, pack(c));
        end
        checks++;
        if (instret !== cnt || w_instret !== cnt[3:0]) begin
          errors++;
          $display("FAIL random_instret got=%0d/%0d exp=%0d", instret, w_instret, cnt);
        end
        if (c.pcw) cnt++;
      end
    end
  endtask

  task automatic test_wrap();
    cyc_t c;
    test_reset();
    for (int k = 0; k < 16; k++) build(32'h00A50533, 0, 0, 0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      c.rdy = (c.st == 3'd0) ? 1'b1 : c.rdy;
      drive(c);
      checks++;
      if (w_instret !== cnt[3:0]) begin
        errors++;
        $display("FAIL wrap_step got=%0d exp=%0d", w_instret, cnt[3:0]);
      end
      if (c.pcw) cnt++;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (w_instret !== 4'd0 || instret !== 32'd16) begin
      errors++;
      $display("FAIL wrap_final got=%0d/%0d exp=0/16", w_instret, instret);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_alu();
    test_branch();
    test_store_wait();
    test_reset_mid();
    test_illegal();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
